// File: rtl/dpp_pulse_counter.sv
// Threshold pulse detector with peak capture, holdoff and per-gate event counting.
// Optional pile-up rejection is compiled in with `define DPP_PILEUP_REJECT_EN.
module dpp_pulse_counter #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 32,
    parameter int HOLDOFF   = 8,
    parameter int MAX_WIDTH = 64
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              cfg_enable,
    input  logic              cfg_clear,
    input  logic [DATA_W-1:0] cfg_threshold,
    input  logic [31:0]       cfg_gate_len,
    output logic              evt_valid,
    output logic [DATA_W-1:0] evt_peak,
    output logic [CNT_W-1:0]  cnt_live,
    output logic [CNT_W-1:0]  cnt_gate,
    output logic              gate_done,
    output logic              cnt_ovf,
    output logic [15:0]       rej_cnt,
    output logic [1:0]        dbg_state
);

    localparam int HO_W = $clog2(HOLDOFF + 1);

    if (HOLDOFF < 1 || MAX_WIDTH < 1) begin : g_bad_param
        $error("dpp_pulse_counter: HOLDOFF and MAX_WIDTH must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BELOW = 2'd1,
        ST_ABOVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   peak_q, peak_d;
    logic [HO_W-1:0]     hold_q, hold_d;
    logic [31:0]         timer_q, timer_d;
    logic [CNT_W-1:0]    live_q, live_d;
    logic [CNT_W-1:0]    gate_q, gate_d;
    logic                ovf_q, ovf_d;
    logic                evt_q, evt_d;
    logic [DATA_W-1:0]   epeak_q, epeak_d;
    logic                gdone_q, gdone_d;

    logic above;
    logic pulse_end;
    logic reject;
    logic accept;
    logic gate_hit;

    assign above = s_valid && ($signed(s_data) > $signed(cfg_threshold));

`ifdef DPP_PILEUP_REJECT_EN
    localparam int WID_W = $clog2(MAX_WIDTH + 2);
    logic [WID_W-1:0] width_q, width_d;
    logic [15:0]      rej_q, rej_d;
    assign reject  = width_q > WID_W'(MAX_WIDTH);
    assign rej_cnt = rej_q;
`else
    assign reject  = 1'b0;
    assign rej_cnt = '0;
`endif

    // Pulse FSM: disable and clear both drop any in-flight pulse silently.
    always_comb begin
        state_d   = state_q;
        peak_d    = peak_q;
        hold_d    = hold_q;
        pulse_end = 1'b0;
`ifdef DPP_PILEUP_REJECT_EN
        width_d   = width_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_BELOW;
            ST_BELOW: begin
                if (above) begin
                    state_d = ST_ABOVE;
                    peak_d  = s_data;
`ifdef DPP_PILEUP_REJECT_EN
                    width_d = WID_W'(1);
`endif
                end
            end
            ST_ABOVE: begin
                if (above) begin
                    if ($signed(s_data) > $signed(peak_q)) peak_d = s_data;
`ifdef DPP_PILEUP_REJECT_EN
                    if (width_q != '1) width_d = width_q + WID_W'(1);
`endif
                end else if (s_valid) begin
                    pulse_end = 1'b1;
                    state_d   = ST_HOLD;
                    hold_d    = HO_W'(HOLDOFF);
                end
            end
            ST_HOLD: begin
                if (s_valid) begin
                    if (hold_q == '0) begin
                        if (!above) state_d = ST_BELOW;
                    end else begin
                        hold_d = hold_q - HO_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cfg_clear) begin
            state_d   = cfg_enable ? ST_BELOW : ST_IDLE;
            pulse_end = 1'b0;
        end else if (!cfg_enable) begin
            state_d   = ST_IDLE;
            pulse_end = 1'b0;
        end
    end

    assign accept   = pulse_end && !reject;
    assign gate_hit = cfg_enable && (cfg_gate_len != 32'd0) &&
                      (timer_q >= cfg_gate_len - 32'd1);

    // Counters and gate; an event on the boundary cycle opens the new gate.
    always_comb begin
        timer_d = timer_q;
        live_d  = live_q;
        gate_d  = gate_q;
        ovf_d   = ovf_q;
        evt_d   = accept;
        epeak_d = accept ? peak_q : epeak_q;
        gdone_d = 1'b0;
`ifdef DPP_PILEUP_REJECT_EN
        rej_d   = rej_q;
        if (pulse_end && reject && rej_q != '1) rej_d = rej_q + 16'd1;
`endif
        if (!cfg_enable || cfg_gate_len == 32'd0) begin
            timer_d = '0;
        end else if (gate_hit) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 32'd1;
        end
        if (gate_hit) begin
            gate_d  = live_q;
            gdone_d = 1'b1;
            live_d  = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            if (live_q == '1) ovf_d = 1'b1;
            else              live_d = live_q + CNT_W'(1);
        end
        if (cfg_clear) begin
            timer_d = '0;
            live_d  = '0;
            gate_d  = '0;
            ovf_d   = 1'b0;
            evt_d   = 1'b0;
            epeak_d = '0;
            gdone_d = 1'b0;
`ifdef DPP_PILEUP_REJECT_EN
            rej_d   = '0;
`endif
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            peak_q  <= '0;
            hold_q  <= '0;
            timer_q <= '0;
            live_q  <= '0;
            gate_q  <= '0;
            ovf_q   <= 1'b0;
            evt_q   <= 1'b0;
            epeak_q <= '0;
            gdone_q <= 1'b0;
`ifdef DPP_PILEUP_REJECT_EN
            width_q <= '0;
            rej_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
            timer_q <= timer_d;
            live_q  <= live_d;
            gate_q  <= gate_d;
            ovf_q   <= ovf_d;
            evt_q   <= evt_d;
            epeak_q <= epeak_d;
            gdone_q <= gdone_d;
`ifdef DPP_PILEUP_REJECT_EN
            width_q <= width_d;
            rej_q   <= rej_d;
`endif
        end
    end

    assign evt_valid = evt_q;
    assign evt_peak  = epeak_q;
    assign cnt_live  = live_q;
    assign cnt_gate  = gate_q;
    assign gate_done = gdone_q;
    assign cnt_ovf   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dpp_pulse_counter.sv
// Directed bench for dpp_pulse_counter (CNT_W=4 so saturation is reachable).
module tb_dpp_pulse_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        cfg_enable = 1'b0;
    logic        cfg_clear = 1'b0;
    logic [15:0] cfg_threshold = 16'd100;
    logic [31:0] cfg_gate_len = '0;
    logic        evt_valid;
    logic [15:0] evt_peak;
    logic [3:0]  cnt_live;
    logic [3:0]  cnt_gate;
    logic        gate_done;
    logic        cnt_ovf;
    logic [15:0] rej_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int evt_seen = 0;

    always #5 clk = ~clk;

    dpp_pulse_counter #(
        .DATA_W(16), .CNT_W(4), .HOLDOFF(8), .MAX_WIDTH(64)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .s_data(s_data), .s_valid(s_valid),
        .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
        .cfg_threshold(cfg_threshold), .cfg_gate_len(cfg_gate_len),
        .evt_valid(evt_valid), .evt_peak(evt_peak),
        .cnt_live(cnt_live), .cnt_gate(cnt_gate),
        .gate_done(gate_done), .cnt_ovf(cnt_ovf),
        .rej_cnt(rej_cnt), .dbg_state(dbg_state)
    );

    always @(negedge clk) if (evt_valid) evt_seen++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 16'd0);
    endtask

    // n samples at amp, falling sample, then 10 low samples to clear holdoff
    task automatic pulse(input int n, input logic [15:0] amp);
        for (int i = 0; i < n; i++) step(1'b1, amp);
        step(1'b1, 16'd50);
        idle(10);
    endtask

    task automatic do_clear();
        cfg_clear = 1'b1;
        step(1'b1, 16'd0);
        cfg_clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_live", 32'(cnt_live), 0);
        check_val("rst_evt", 32'(evt_valid), 0);
        check_val("rst_state", 32'(dbg_state), 0);
        check_val("rst_ovf", 32'(cnt_ovf), 0);
        rst_n = 1'b1;

        // basic detection and latency
        cfg_enable = 1'b1;
        step(1'b1, 16'd0);
        step(1'b1, 16'd150);
        step(1'b1, 16'd300);
        step(1'b1, 16'd200);
        check_val("pre_evt", 32'(evt_valid), 0);
        step(1'b1, 16'd50);
        check_val("evt_strobe", 32'(evt_valid), 1);
        check_val("evt_peak", 32'(evt_peak), 300);
        check_val("live_1", 32'(cnt_live), 1);
        step(1'b1, 16'd0);
        check_val("evt_one_cycle", 32'(evt_valid), 0);

        // retrigger inside holdoff is ignored
        step(1'b1, 16'd0);
        step(1'b1, 16'd150);
        step(1'b1, 16'd150);
        step(1'b1, 16'd50);
        idle(12);
        check_val("holdoff_ignored", 32'(cnt_live), 1);
        check_val("holdoff_evts", 32'(evt_seen), 1);

        // pulses spaced beyond holdoff both count
        step(1'b1, 16'd150);
        step(1'b1, 16'd50);
        idle(12);
        step(1'b1, 16'd250);
        step(1'b1, 16'd50);
        check_val("spaced_peak", 32'(evt_peak), 250);
        idle(12);
        check_val("spaced_live", 32'(cnt_live), 3);

        // disable mid-pulse drops it
        step(1'b1, 16'd200);
        check_val("in_above", 32'(dbg_state), 2);
        cfg_enable = 1'b0;
        step(1'b1, 16'd50);
        step(1'b1, 16'd50);
        check_val("dis_state", 32'(dbg_state), 0);
        check_val("dis_evts", 32'(evt_seen), 3);
        check_val("dis_live_held", 32'(cnt_live), 3);
        do_clear();
        check_val("clr_live", 32'(cnt_live), 0);
        check_val("clr_peak", 32'(evt_peak), 0);
        check_val("clr_state", 32'(dbg_state), 0);

        // saturation
        cfg_enable = 1'b1;
        idle(1);
        for (int p = 0; p < 17; p++) pulse(1, 16'd150);
        check_val("sat_live", 32'(cnt_live), 15);
        check_val("sat_ovf", 32'(cnt_ovf), 1);
        idle(3);
        check_val("ovf_sticky", 32'(cnt_ovf), 1);
        do_clear();
        check_val("ovf_clr", 32'(cnt_ovf), 0);
        check_val("ovf_clr_live", 32'(cnt_live), 0);

        // wide pulse: rejected only with pile-up rejection built in
        pulse(80, 16'd150);
`ifdef DPP_PILEUP_REJECT_EN
        check_val("wide_rej", 32'(rej_cnt), 1);
        check_val("wide_live", 32'(cnt_live), 0);
`else
        check_val("wide_rej", 32'(rej_cnt), 0);
        check_val("wide_live", 32'(cnt_live), 1);
`endif
        pulse(10, 16'd150);
`ifdef DPP_PILEUP_REJECT_EN
        check_val("narrow_live", 32'(cnt_live), 1);
`else
        check_val("narrow_live", 32'(cnt_live), 2);
`endif
        do_clear();
        check_val("rej_clr", 32'(rej_cnt), 0);

        // gating: 1000-cycle gates, timer restarts at the clear edge
        cfg_gate_len = 32'd1000;
        do_clear();
        cyc = 0;
        for (int p = 0; p < 5; p++) pulse(1, 16'd150);
        while (cyc < 999) step(1'b1, 16'd0);
        check_val("gate_pre", 32'(gate_done), 0);
        check_val("gate_pre_live", 32'(cnt_live), 5);
        step(1'b1, 16'd0);
        check_val("gate_done", 32'(gate_done), 1);
        check_val("gate_cnt", 32'(cnt_gate), 5);
        check_val("gate_live0", 32'(cnt_live), 0);
        step(1'b1, 16'd0);
        check_val("gate_strobe", 32'(gate_done), 0);
        for (int p = 0; p < 2; p++) pulse(1, 16'd150);
        while (cyc < 1997) step(1'b1, 16'd0);
        step(1'b1, 16'd150);
        step(1'b1, 16'd150);
        step(1'b1, 16'd50);
        check_val("bnd_done", 32'(gate_done), 1);
        check_val("bnd_gate", 32'(cnt_gate), 2);
        check_val("bnd_live", 32'(cnt_live), 1);
        check_val("bnd_evt", 32'(evt_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
